seq_magnitude_comparator: RTL and testbench

Parametrised multi-cycle magnitude comparator. Compares two WIDTH-bit operands, DIGIT bits per clock, starting at the MSB. Supports an unsigned mode and a two's-complement signed mode, and terminates early at the first differing digit. Used where a wide comparison must not sit on the critical path. It replaces fixed-width combinational comparators behind a start/done handshake.

---
 rtl/seq_magnitude_comparator_if.sv | 31 +++
 rtl/seq_magnitude_comparator.sv | 127 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake/operand bundle for seq_magnitude_comparator.
//   start        : request, accepted on a rising edge while busy is low
//   a, b         : WIDTH-bit operands, sampled on the accepting edge
//   signed_mode  : 1 = two's-complement compare, sampled with the operands
//   busy         : comparison in progress
//   done         : one-cycle pulse, g/e/l valid
//   g, e, l      : A > B, A == B, A < B (held until the next result or reset)
// master drives the request side; slave is the comparator.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             g;
  logic             e;
  logic             l;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, g, e, l
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, g, e, l
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator. Walks the captured operands DIGIT bits
// per clock from the MSB down and stops at the first differing digit, so a
// wide compare never sits in one combinational path.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seq_magnitude_comparator_if.slave (start/a/b/signed_mode in,
//            busy/done/g/e/l out)
module seq_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic                          clk,
  input logic                          rst_n,
  seq_magnitude_comparator_if.slave    bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  // Operands stored as a digit array so the current digit is a plain index.
  logic [N-1:0][DIGIT-1:0]   a_q, a_d;
  logic [N-1:0][DIGIT-1:0]   b_q, b_d;
  logic                      sm_q, sm_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      done_q, done_d;
  logic                      g_q, g_d;
  logic                      e_q, e_d;
  logic                      l_q, l_d;

  logic [DIGIT-1:0]          dig_a, dig_b;
  logic                      sign_split;

  assign dig_a = a_q[cnt_q];
  assign dig_b = b_q[cnt_q];

  // Differing sign bits settle a signed compare on the top digit; with equal
  // sign bits the unsigned digit walk already gives two's-complement order.
  assign sign_split = sm_q && (cnt_q == CW'(N - 1)) &&
                      (a_q[N-1][DIGIT-1] != b_q[N-1][DIGIT-1]);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sm_d    = bus.signed_mode;
          cnt_d   = CW'(N - 1);
          state_d = RUN;
        end
      end

      RUN: begin
        if (sign_split) begin
          // Operand carrying the set sign bit is the negative one.
          g_d     = b_q[N-1][DIGIT-1];
          e_d     = 1'b0;
          l_d     = a_q[N-1][DIGIT-1];
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (dig_a != dig_b) begin
          g_d     = (dig_a > dig_b);
          e_d     = 1'b0;
          l_d     = (dig_a < dig_b);
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - CW'(1);
        end else begin
          g_d     = 1'b0;
          e_d     = 1'b1;
          l_d     = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
    end
  end

  // busy is exactly "in RUN", so reset drops it without an extra register.
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.g    = g_q;
  assign bus.e    = e_q;
  assign bus.l    = l_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: directed cases on an 8/2 instance,
// randomized cases on 16/4 and 6/1 instances against an arithmetic model.
module tb_seq_magnitude_comparator;

  logic clk;
  logic rst_n;
  logic go;

  int n_chk;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- 8-bit, 2 bits per digit ----------------
  seq_magnitude_comparator_if #(.WIDTH(8)) i8 ();

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8)
  );

  // Called at #1 after a rising edge; returns #1 after the accepting edge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    i8.start       = 1'b1;
    i8.a           = a;
    i8.b           = b;
    i8.signed_mode = sm;
    @(posedge clk); #1;
    i8.start       = 1'b0;
    i8.a           = ~a;
    i8.b           = ~b;
    i8.signed_mode = ~sm;
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sm, input int lat, input logic [2:0] gel);
    go8(a, b, sm);
    for (int k = 1; k < lat; k++) begin
      @(posedge clk); #1;
      check({tag, "_busy"}, int'({i8.busy, i8.done}), int'(2'b10));
    end
    @(posedge clk); #1;
    check({tag, "_done"}, int'({i8.busy, i8.done}), int'(2'b01));
    check({tag, "_gel"}, int'({i8.g, i8.e, i8.l}), int'(gel));
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : sw
    localparam int W = (gi == 0) ? 16 : 6;
    localparam int D = (gi == 0) ? 4 : 1;
    localparam int N = W / D;

    bit fin;

    seq_magnitude_comparator_if #(.WIDTH(W)) ifc ();

    seq_magnitude_comparator #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );

    // Reference: numeric compare of the operand values; latency from the
    // position of the highest differing bit.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic s, output logic [2:0] gel,
                                  output int lat);
      longint xv, yv;
      logic [W-1:0] diff;
      int h;
      if (s) begin
        xv = longint'($signed(x));
        yv = longint'($signed(y));
      end else begin
        xv = longint'(x);
        yv = longint'(y);
      end
      if (xv > yv)      gel = 3'b100;
      else if (xv < yv) gel = 3'b001;
      else              gel = 3'b010;
      diff = x ^ y;
      h = -1;
      for (int i = 0; i < W; i++) if (diff[i]) h = i;
      lat = (h < 0) ? N : N - (h / D);
    endfunction

    initial begin : stim
      logic [W-1:0] ra, rb;
      logic         rsm;
      logic [2:0]   egel;
      int           elat, lat;
      bit           b2b;
      fin             = 1'b0;
      ifc.start       = 1'b0;
      ifc.a           = '0;
      ifc.b           = '0;
      ifc.signed_mode = 1'b0;
      wait (go);
      b2b = 1'b0;
      for (int t = 0; t < 60; t++) begin
        if (!b2b) begin
          @(posedge clk); #1;
        end
        ra  = W'($urandom);
        rb  = W'($urandom);
        rsm = 1'($urandom);
        case ($urandom_range(0, 5))
          0: rb = ra;
          1: rb = ra ^ W'(1);
          2: rb = ra ^ (W'(1) << (W - 1));
          default: ;
        endcase
        model(ra, rb, rsm, egel, elat);
        ifc.start       = 1'b1;
        ifc.a           = ra;
        ifc.b           = rb;
        ifc.signed_mode = rsm;
        @(posedge clk); #1;
        ifc.start       = 1'b0;
        ifc.a           = ~ra;
        ifc.b           = ~rb;
        ifc.signed_mode = ~rsm;
        lat = 0;
        do begin
          @(posedge clk); #1;
          lat++;
        end while (!ifc.done && lat < N + 2);
        check($sformatf("sw%0d_lat", W), lat, elat);
        check($sformatf("sw%0d_gel", W), int'({ifc.g, ifc.e, ifc.l}), int'(egel));
        b2b = 1'($urandom_range(0, 1));
      end
      fin = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_chk          = 0;
    n_pass         = 0;
    go             = 1'b0;
    rst_n          = 1'b0;
    i8.start       = 1'b0;
    i8.a           = '0;
    i8.b           = '0;
    i8.signed_mode = 1'b0;

    @(posedge clk); #1;
    check("reset_outs", int'({i8.busy, i8.done, i8.g, i8.e, i8.l}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", int'({i8.busy, i8.done, i8.g, i8.e, i8.l}), 0);

    // Equal operands walk all four digits.
    run8("eq5A", 8'h5A, 8'h5A, 1'b0, 4, 3'b010);
    @(posedge clk); #1;
    check("eq5A_pulse", int'({i8.busy, i8.done}), 0);
    check("eq5A_hold", int'({i8.g, i8.e, i8.l}), int'(3'b010));

    // Top digit decides; signed mode flips the order.
    run8("u80_7F", 8'h80, 8'h7F, 1'b0, 1, 3'b100);
    run8("s80_7F", 8'h80, 8'h7F, 1'b1, 1, 3'b001);

    // Difference only in digit 0.
    run8("u12_13", 8'h12, 8'h13, 1'b0, 4, 3'b001);
    run8("sFE_FF", 8'hFE, 8'hFF, 1'b1, 4, 3'b001);
    run8("u01_00", 8'h01, 8'h00, 1'b0, 4, 3'b100);

    // Start while busy is ignored.
    @(posedge clk); #1;
    go8(8'h10, 8'h30, 1'b0);
    i8.start = 1'b1;
    i8.a     = 8'hFF;
    i8.b     = 8'h00;
    @(posedge clk); #1;
    i8.start = 1'b0;
    check("ign_busy", int'({i8.busy, i8.done}), int'(2'b10));
    @(posedge clk); #1;
    check("ign_done", int'({i8.busy, i8.done}), int'(2'b01));
    check("ign_gel", int'({i8.g, i8.e, i8.l}), int'(3'b001));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("ign_hold", int'({i8.busy, i8.done, i8.g, i8.e, i8.l}), int'(5'b00001));
    end

    // Asynchronous reset mid-compare.
    go8(8'hAA, 8'hAA, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_pre_busy", int'(i8.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", int'({i8.busy, i8.done, i8.g, i8.e, i8.l}), 0);
    @(posedge clk); #1;
    check("rst_held", int'({i8.busy, i8.done, i8.g, i8.e, i8.l}), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("rst_nodone", int'({i8.busy, i8.done}), 0);
    end
    run8("post_rst", 8'h01, 8'h00, 1'b0, 4, 3'b100);

    // Random sweep on the other two instances.
    @(posedge clk); #1;
    go = 1'b1;
    for (int k = 0; k < 20000 && !(sw[0].fin && sw[1].fin); k++) @(posedge clk);
    check("sweep_complete", int'({sw[0].fin, sw[1].fin}), int'(2'b11));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
